// File: rtl/memory_stage.sv
// memory_stage -- load/store stage of the integer pipeline.
//
// Accepts one instruction at a time from execute. ALU results go straight to
// the register-file write port one cycle later, so non-memory ops run at full
// throughput. Loads and stores issue one request on a simple req/gnt +
// rvalid memory port. Loads sign- or zero-extend the selected lane. Stores
// replicate the data across byte lanes and select lanes with a byte strobe.
// A wait counter aborts a stalled transaction with a one-cycle bus_error.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : handshake from execute (ready only when idle)
//   is_load, is_store     : memory op kind; neither means plain ALU result
//   funct3                : access size [1:0] and unsigned-load flag [2]
//   rd, writes_rd         : destination register and its write request
//   alu_result            : byte address for memory ops, result otherwise
//   store_data            : store payload (low bits used for SB/SH)
//   mem_req/we/addr/wdata/wstrb : request side of the memory port
//   mem_gnt, mem_rvalid, mem_rdata : memory responses
//   write_control         : register-file write port (enable is a pulse)
//   bus_error, misaligned : one-cycle fault pulses
//
// Build option
//   MEMORY_STAGE_MISALIGN_TRAP_EN : misaligned halfword/word accesses raise
//   misaligned and are dropped. When it is undefined, the offending low
//   address bits are cleared and the access proceeds.

package memory_stage_pkg;
    localparam int XLEN = 32;

    typedef logic [4:0] rv_reg_t;

    typedef struct packed {
        logic            enable;
        rv_reg_t         which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  rv_reg_t            rd,
    input  logic               writes_rd,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    store_data,
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output reg_write_control_t write_control,
    output logic               bus_error,
    output logic               misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

    // Abort fires once the counter has covered TIMEOUT_CYCLES waiting cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Lane offset after clearing bits that a halfword/word access ignores.
    function automatic logic [1:0] align_offset(input logic [2:0] f3,
                                                input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return lo;
            2'b01:   return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return |lo;
        endcase
    endfunction
`endif

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] word);
        logic [XLEN-1:0]    shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        shifted = word >> {off, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (f3)
            3'b000:  return XLEN'(byte_s);          // LB: sign-extend
            3'b001:  return XLEN'(half_s);          // LH: sign-extend
            3'b100:  return XLEN'(shifted[7:0]);    // LBU
            3'b101:  return XLEN'(shifted[15:0]);   // LHU
            default: return word;                   // LW
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0]      f3,
                                                    input logic [XLEN-1:0] data);
        case (f3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                                input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    state_t          state;
    logic [7:0]      wait_cnt;
    logic            is_load_p1;
    logic            wr_en_p1;
    rv_reg_t         rd_p1;
    logic [2:0]      funct3_p1;
    logic [1:0]      off_p1;
    logic            vld_p1;
    rv_reg_t         wc_reg;
    logic [XLEN-1:0] wc_value;
    logic            bus_error_q;

    logic            accept;
    logic            mem_op;
    logic [1:0]      off_p0;
    logic            trap_p0;
    logic            timeout_hit;

    assign in_ready    = (state == IDLE);
    assign accept      = in_ready && in_valid;
    assign mem_op      = is_load || is_store;
    assign off_p0      = align_offset(funct3, alu_result[1:0]);
    assign timeout_hit = (wait_cnt >= TIMEOUT_LAST);

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign trap_p0    = mem_op && is_misaligned(funct3, alu_result[1:0]);
    assign misaligned = misaligned_q;
`else
    assign trap_p0    = 1'b0;
    assign misaligned = 1'b0;
`endif

    // ---- p0 -> p1: accept from execute, control path ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= 4'b0000;
            vld_p1       <= 1'b0;
            bus_error_q  <= 1'b0;
            is_load_p1   <= 1'b0;
            wr_en_p1     <= 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            vld_p1       <= 1'b0;
            bus_error_q  <= 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mem_op) begin
                            vld_p1 <= writes_rd && (rd != '0);
                        end else if (trap_p0) begin
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
                            misaligned_q <= 1'b1;
`endif
                        end else begin
                            state      <= REQ;
                            wait_cnt   <= 8'd0;
                            mem_req    <= 1'b1;
                            mem_we     <= is_store && !is_load;
                            mem_wstrb  <= (is_store && !is_load) ?
                                          store_strobe(funct3, off_p0) : 4'b0000;
                            is_load_p1 <= is_load;
                            wr_en_p1   <= writes_rd && (rd != '0);
                        end
                    end
                end
                REQ: begin
                    if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                    // A grant on the timeout cycle still completes the request.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= is_load_p1 ? WAIT_DATA : IDLE;
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        bus_error_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WAIT_DATA: begin
                    if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                    if (mem_rvalid) begin
                        vld_p1 <= wr_en_p1;
                        state  <= IDLE;
                    end else if (timeout_hit) begin
                        bus_error_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- p0 -> p1: data path (no reset; qualified by state) ----
    always_ff @(posedge clock) begin
        if (accept) begin
            if (mem_op) begin
                mem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                mem_wdata <= store_lanes(funct3, store_data);
                funct3_p1 <= funct3;
                off_p1    <= off_p0;
                rd_p1     <= rd;
            end else begin
                wc_reg   <= rd;
                wc_value <= alu_result;
            end
        end else if (state == WAIT_DATA && mem_rvalid) begin
            wc_reg   <= rd_p1;
            wc_value <= load_extract(funct3_p1, off_p1, mem_rdata);
        end
    end

    assign bus_error     = bus_error_q;
    assign write_control = '{enable: vld_p1, which_register: wc_reg, value: wc_value};

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads with lane
// extraction, stores with strobes, timeout abort, grant/timeout priority,
// asynchronous reset mid-transaction and misaligned handling for either build.

module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int TMO = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               is_load;
    logic               is_store;
    logic [2:0]         funct3;
    rv_reg_t            rd;
    logic               writes_rd;
    logic [31:0]        alu_result;
    logic [31:0]        store_data;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    reg_write_control_t write_control;
    logic               bus_error;
    logic               misaligned;

    int vectors = 0;
    int miscompares = 0;

    memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .rd(rd),
        .writes_rd(writes_rd), .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_control(write_control), .bus_error(bus_error),
        .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] sd);
        in_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        rd         = r;
        writes_rd  = 1'b1;
        alu_result = a;
        store_data = sd;
        tick();
        in_valid   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
    endtask

    // Accept, two ungranted cycles (with stray rvalid), grant, two idle data
    // cycles, then rvalid carrying rdata.
    task automatic run_load(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, 5'd7, addr, 32'h0);
        check_vec({tag, "_req"}, 32'(mem_req), 32'd1);
        check_vec({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check_vec({tag, "_rdy"}, 32'(in_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        tick();
        tick();
        mem_rvalid = 1'b0;
        check_vec({tag, "_noearly"}, 32'(write_control.enable), 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_vec({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
        tick();
        tick();
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check_vec({tag, "_en"}, 32'(write_control.enable), 32'd1);
        check_vec({tag, "_rd"}, 32'(write_control.which_register), 32'd7);
        check_vec({tag, "_val"}, write_control.value, exp);
        tick();
        check_vec({tag, "_pulse"}, 32'(write_control.enable), 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, 5'd9, addr, sd);
        tick();  // one ungranted cycle: outputs must hold
        check_vec({tag, "_req"}, 32'(mem_req), 32'd1);
        check_vec({tag, "_we"}, 32'(mem_we), 32'd1);
        check_vec({tag, "_addr"}, mem_addr, exp_addr);
        check_vec({tag, "_strb"}, 32'(mem_wstrb), 32'(exp_strb));
        check_vec({tag, "_wdata"}, mem_wdata, exp_wdata);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_vec({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
        check_vec({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check_vec({tag, "_nowr"}, 32'(write_control.enable), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        rd = '0; writes_rd = 1'b0; alu_result = '0; store_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check_vec("rst_req", 32'(mem_req), 32'd0);
        check_vec("rst_we", 32'(mem_we), 32'd0);
        check_vec("rst_strb", 32'(mem_wstrb), 32'd0);
        check_vec("rst_en", 32'(write_control.enable), 32'd0);
        check_vec("rst_berr", 32'(bus_error), 32'd0);
        check_vec("rst_mis", 32'(misaligned), 32'd0);
        reset = 1'b0;
        check_vec("rst_rdy", 32'(in_ready), 32'd1);

        // ALU pass-through
        issue(1'b0, 1'b0, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
        check_vec("alu_en", 32'(write_control.enable), 32'd1);
        check_vec("alu_rd", 32'(write_control.which_register), 32'd5);
        check_vec("alu_val", write_control.value, 32'h0000_1234);
        check_vec("alu_rdy", 32'(in_ready), 32'd1);
        issue(1'b0, 1'b0, 3'd0, 5'd0, 32'h0000_5678, 32'h0);
        check_vec("alu_x0_en", 32'(write_control.enable), 32'd0);

        // Loads
        run_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080);
        run_load("lh",  3'b001, 32'h0000_0402, 32'h80FF_1234, 32'hFFFF_80FF);
        run_load("lhu", 3'b101, 32'h0000_0402, 32'h80FF_1234, 32'h0000_80FF);
        run_load("lw",  3'b010, 32'h0000_0500, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Stores
        run_store("sh", 3'b001, 32'h0000_0202, 32'h0000_ABCD,
                  32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        run_store("sb", 3'b000, 32'h0000_0301, 32'h1234_565A,
                  32'h0000_0300, 4'b0010, 32'h5A5A_5A5A);
        run_store("sw", 3'b010, 32'h0000_0304, 32'h1122_3344,
                  32'h0000_0304, 4'b1111, 32'h1122_3344);

        // Timeout: no grant ever
        issue(1'b1, 1'b0, 3'b010, 5'd3, 32'h0000_0010, 32'h0);
        n = 0;
        while (mem_req && n < 100) begin
            tick();
            n++;
        end
        check_vec("tmo_cycles", 32'(n), 32'(TMO));
        check_vec("tmo_berr", 32'(bus_error), 32'd1);
        check_vec("tmo_rdy", 32'(in_ready), 32'd1);
        check_vec("tmo_nowr", 32'(write_control.enable), 32'd0);
        tick();
        check_vec("tmo_pulse", 32'(bus_error), 32'd0);

        // Grant on the timeout cycle wins; rvalid past the limit also wins
        issue(1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0020, 32'h0);
        for (int i = 0; i < TMO - 1; i++) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_vec("prio_gnt_berr", 32'(bus_error), 32'd0);
        check_vec("prio_gnt_rdy", 32'(in_ready), 32'd0);
        mem_rdata  = 32'h0BAD_CAFE;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check_vec("prio_rv_en", 32'(write_control.enable), 32'd1);
        check_vec("prio_rv_val", write_control.value, 32'h0BAD_CAFE);
        check_vec("prio_rv_berr", 32'(bus_error), 32'd0);

        // Asynchronous reset while waiting for data
        issue(1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0040, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_vec("arst_pre_rdy", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_vec("arst_rdy", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        mem_rdata  = 32'h1111_2222;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check_vec("arst_nowr", 32'(write_control.enable), 32'd0);
        tick();
        check_vec("arst_nowr2", 32'(write_control.enable), 32'd0);

        // Misaligned word access at 0x001
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_0001, 32'h0);
        check_vec("mis_pulse", 32'(misaligned), 32'd1);
        check_vec("mis_noreq", 32'(mem_req), 32'd0);
        check_vec("mis_rdy", 32'(in_ready), 32'd1);
        check_vec("mis_nowr", 32'(write_control.enable), 32'd0);
        tick();
        check_vec("mis_clear", 32'(misaligned), 32'd0);
`else
        run_load("lw_mis", 3'b010, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check_vec("mis_tied", 32'(misaligned), 32'd0);
        run_load("lh_mis", 3'b001, 32'h0000_0003, 32'h80FF_1234, 32'hFFFF_80FF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
